// File: rtl/master_pkg.sv
// Types and constants shared by the master-domain write path.
package master_pkg;
    localparam int MASTER_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;
endpackage

// File: rtl/master_write_sequencer.sv
// Bursts incrementing words into the CDC FIFO after a start pulse; first write the cycle after start, done the cycle after the last accept.
// Backpressure: w_en is gated combinationally by full, so a stall holds data and counts with no timeout.
module master_write_sequencer
    import master_pkg::*;
#(
    parameter int DATA_W = MASTER_DATA_W,
    parameter int LEN_W  = 5,
    parameter int STEP   = 1
) (
    input  logic              clk_master,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] start_value,
    input  logic              abort,
    input  logic              full,
    output logic              w_en,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_written
);
    localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);
    localparam logic [LEN_W-1:0]  ONE    = LEN_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_aborted;
    logic              w_accept;
    logic              w_launch;

    // Abort wins over a write in the same cycle.
    assign w_accept = (r_state == WRITE) && !full && !abort;
    assign w_launch = (r_state == IDLE) && start;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (burst_len == '0) ? FINISH : WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (!full && r_remaining == ONE) begin
                    w_next_state = FINISH;
                end
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_aborted <= (r_state == WRITE) && abort;
            if (w_launch) begin
                r_count <= '0;
                if (burst_len != '0) begin
                    r_remaining <= burst_len;
                    r_data      <= start_value;
                end
            end else if (w_accept) begin
                r_data      <= r_data + STEP_V;
                r_remaining <= r_remaining - ONE;
                r_count     <= r_count + ONE;
            end
        end
    end

    assign w_en          = w_accept;
    assign write_data    = r_data;
    assign busy          = (r_state == WRITE);
    assign done          = (r_state == FINISH);
    assign aborted       = r_aborted;
    assign words_written = r_count;
endmodule
